// File: rtl/tt_um_hoene_led_pkg.sv
// Shared state encoding and 50 MHz default timing constants for the smart-LED bit decoder.
package tt_um_hoene_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam int DEF_CNT_W        = 12;
    localparam int DEF_THRESHOLD    = 30;
    localparam int DEF_HIGH_MAX     = 100;
    localparam int DEF_RESET_CYCLES = 2500;

endpackage

// File: rtl/tt_um_hoene_pulse_timer.sv
// Saturating run-length counter: clear restarts the run (at 1 when inc is also set).
module tt_um_hoene_pulse_timer
    import tt_um_hoene_led_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= {{(CNT_W-1){1'b0}}, inc};
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/tt_um_hoene_led_bit_decoder.sv
// Pulse-width decoder: classifies filtered high pulses as bits, assembles MSB-first bytes,
// and flags line reset (long low) and overlong highs.
module tt_um_hoene_led_bit_decoder
    import tt_um_hoene_led_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int THRESHOLD    = DEF_THRESHOLD,
    parameter int HIGH_MAX     = DEF_HIGH_MAX,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       led_reset,
    output logic       error,
    output logic       busy
);

    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_MAX - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RESET_CYCLES - 1);

    state_t           state_reg;
    logic [6:0]       shift_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       data_out_reg;
    logic             data_valid_reg;
    logic             led_reset_reg;
    logic             error_reg;

    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             high_last;
    logic             low_last;
    logic             bit_val;

    // cnt holds the length of the current run up to (not including) this sample.
    assign high_last = (cnt == HIGH_LAST);
    assign low_last  = (cnt == LOW_LAST);
    assign bit_val   = (cnt >= THRESH_C);

    tt_um_hoene_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .cnt   (cnt)
    );

    // Entering ERROR or IDLE zeroes the counter so the following low run counts from 1.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                cnt_inc   = din;
            end
            HIGH: begin
                if (din) begin
                    cnt_clear = high_last;
                    cnt_inc   = !high_last;
                end else begin
                    cnt_clear = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            LOW: begin
                if (din) begin
                    cnt_clear = 1'b1;
                    cnt_inc   = 1'b1;
                end else begin
                    cnt_clear = low_last;
                    cnt_inc   = !low_last;
                end
            end
            ERROR: begin
                if (din) begin
                    cnt_clear = 1'b1;
                end else begin
                    cnt_clear = low_last;
                    cnt_inc   = !low_last;
                end
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            led_reset_reg  <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            led_reset_reg  <= 1'b0;
            error_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (din) state_reg <= HIGH;
                end
                HIGH: begin
                    if (din) begin
                        if (high_last) begin
                            state_reg   <= ERROR;
                            error_reg   <= 1'b1;
                            bit_cnt_reg <= '0;
                        end
                    end else begin
                        state_reg <= LOW;
                        shift_reg <= {shift_reg[5:0], bit_val};
                        if (bit_cnt_reg == 3'd7) begin
                            data_out_reg   <= {shift_reg, bit_val};
                            data_valid_reg <= 1'b1;
                        end
                        // The 3-bit counter wraps 7 -> 0 at the byte boundary.
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                end
                LOW: begin
                    if (din) begin
                        state_reg <= HIGH;
                    end else if (low_last) begin
                        state_reg     <= IDLE;
                        led_reset_reg <= 1'b1;
                        bit_cnt_reg   <= '0;
                    end
                end
                ERROR: begin
                    if (!din && low_last) begin
                        state_reg     <= IDLE;
                        led_reset_reg <= 1'b1;
                        bit_cnt_reg   <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign led_reset  = led_reset_reg;
    assign error      = error_reg;
    assign busy       = (state_reg != IDLE);

endmodule
